// File: rtl/sram_1r1w_tiled_pkg.sv
// Shared types and elaboration helpers for the tiled 1R1W SRAM.
package sram_pkg;

  // Upper bound on byte lanes handled by the mask helpers.
  localparam int MAX_NB = 128;

  // Zero-fill sequencer: INIT sweeps every macro address, DONE opens the ports.
  typedef enum logic {
    INIT = 1'b0,
    DONE = 1'b1
  } sram_init_e;

  // Integer ceiling division, used to size the macro column count.
  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Returns the per_col byte-enable bits that belong to macro column col,
  // right-aligned with every bit above the slice cleared.
  function automatic logic [MAX_NB-1:0] byte_mask_slice(
    input logic [MAX_NB-1:0] mask,
    input int                col,
    input int                per_col
  );
    logic [MAX_NB-1:0] s;
    logic [MAX_NB-1:0] keep;
    s    = mask >> (col * per_col);
    keep = ~({MAX_NB{1'b1}} << per_col);
    return s & keep;
  endfunction

endpackage

// File: rtl/sram_1r1w_tiled_macro_tile.sv
// One sky130_sram_1r1w0rw macro slot: active-high enables in, active-low
// chip selects to the macro. The body models the OpenRAM macro port protocol
// (write on clk, read data registered one clock after the select).
module sram_macro_tile #(
  parameter int DW = 32,
  parameter int AW = 6,
  parameter int NM = 4
) (
  input  logic          clk,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [NM-1:0] wmask,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int GW = DW / NM;

  logic          csb0;
  logic          csb1;
  logic [NM-1:0] wmask0;
  logic [DW-1:0] mem [2**AW];

  assign csb0 = ~wen;
  assign csb1 = ~ren;

  // Macros without a byte mask always write the full word.
  generate
    if (NM > 1) begin : g_mask
      assign wmask0 = wmask;
    end else begin : g_nomask
      assign wmask0 = {NM{1'b1}};
    end
  endgenerate

  // Write port: masked granule update while csb0 is low.
  always_ff @(posedge clk) begin
    if (!csb0) begin
      for (int g = 0; g < NM; g++) begin
        if (wmask0[g]) begin
          mem[waddr][g*GW +: GW] <= wdata[g*GW +: GW];
        end
      end
    end
  end

  // Read port: array contents captured before any same-edge write lands.
  always_ff @(posedge clk) begin
    if (!csb1) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sram_1r1w_tiled.sv
// Parametrised 1R1W SRAM built from a ROWS x COLS grid of fixed macros, with
// per-byte write mask, write-first collision forwarding, a registered read
// port (latency 2) and a post-reset zero-fill sweep.
module sram_1r1w_tiled
  import sram_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int DEPTH       = 256,
  parameter int BYTE_WIDTH  = 8,
  parameter int MACRO_WIDTH = 32,
  parameter int MACRO_DEPTH = 64,
  parameter int BYPASS      = 1,
  parameter int INIT_ZERO   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          ready,
  input  logic [WIDTH/BYTE_WIDTH-1:0]   we,
  input  logic [$clog2(DEPTH)-1:0]      waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          re,
  input  logic [$clog2(DEPTH)-1:0]      raddr,
  output logic                          rvalid,
  output logic [WIDTH-1:0]              rdata
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int NB     = WIDTH / BYTE_WIDTH;
  localparam int COLS   = ceil_div(WIDTH, MACRO_WIDTH);
  localparam int ROWS   = DEPTH / MACRO_DEPTH;
  localparam int MAW    = $clog2(MACRO_DEPTH);
  localparam int MB     = MACRO_WIDTH / BYTE_WIDTH;
  localparam int PW     = COLS * MACRO_WIDTH;
  localparam int PNB    = COLS * MB;
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1;

  sram_init_e       state;
  sram_init_e       state_next;
  logic [MAW-1:0]   cnt;
  logic [MAW-1:0]   cnt_next;
  logic             init_wr;

  logic             wr_acc;
  logic             rd_acc;
  logic             collide;
  logic [RW-1:0]    wrow;
  logic [RW-1:0]    rrow;
  logic [RW-1:0]    rrow_q;
  logic [MAW-1:0]   wma;
  logic [MAW-1:0]   rma;

  logic [MAX_NB-1:0] we_wide;
  logic [MAX_NB-1:0] pad_wide;
  logic [MAX_NB-1:0] real_slice;
  logic [MAX_NB-1:0] pad_slice;
  logic [MB-1:0]     col_mask [COLS];
  logic [COLS-1:0]   col_en;
  logic [PW-1:0]     wdata_pad;
  logic [PW-1:0]     row_pad;

  logic [WIDTH-1:0]  fwd_bits;
  logic [WIDTH-1:0]  fwd_mask_q;
  logic [WIDTH-1:0]  fwd_data_q;
  logic [WIDTH-1:0]  merged;
  logic              rd_q;

  logic [MACRO_WIDTH-1:0] dout_a [ROWS][COLS];

  // ---------------------------------------------------------------- init FSM

  // Zero-fill sequencer state, sweep counter and the registered ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_ZERO != 0) ? INIT : DONE;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      ready <= (state_next == DONE);
    end
  end

  // Next-state: sweep one macro address per cycle, then stay in DONE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    init_wr    = 1'b0;
    case (state)
      INIT: begin
        init_wr = 1'b1;
        if (cnt == MAW'(MACRO_DEPTH - 1)) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt + MAW'(1);
        end
      end
      DONE: begin
        state_next = DONE;
      end
      default: begin
        state_next = INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------- address decode

  assign wr_acc  = ready & (|we);
  assign rd_acc  = ready & re;
  assign collide = (BYPASS != 0) & wr_acc & rd_acc & (raddr == waddr);
  assign wma     = waddr[MAW-1:0];
  assign rma     = raddr[MAW-1:0];

  generate
    if (ROWS > 1) begin : g_rows
      assign wrow = waddr[ADDR_W-1:MAW];
      assign rrow = raddr[ADDR_W-1:MAW];
    end else begin : g_one_row
      assign wrow = '0;
      assign rrow = '0;
    end
  endgenerate

  assign we_wide   = MAX_NB'(we);
  assign wdata_pad = PW'(wdata);

  // Per-column byte mask: real lanes from we, padding lanes always written
  // (with zero data) whenever their column is selected by a real lane.
  always_comb begin
    pad_wide   = '0;
    real_slice = '0;
    pad_slice  = '0;
    col_en     = '0;
    for (int i = 0; i < MAX_NB; i++) begin
      pad_wide[i] = (i >= NB) && (i < PNB);
    end
    for (int c = 0; c < COLS; c++) begin
      real_slice  = byte_mask_slice(we_wide, c, MB);
      pad_slice   = byte_mask_slice(pad_wide, c, MB);
      col_en[c]   = |real_slice[MB-1:0];
      col_mask[c] = real_slice[MB-1:0] | pad_slice[MB-1:0];
    end
  end

  // ------------------------------------------------------------- macro grid

  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
        logic                   t_wen;
        logic                   t_ren;
        logic [MAW-1:0]         t_waddr;
        logic [MB-1:0]          t_wmask;
        logic [MACRO_WIDTH-1:0] t_wdata;

        assign t_wen   = init_wr | (wr_acc & (wrow == RW'(r)) & col_en[c]);
        assign t_ren   = rd_acc & (rrow == RW'(r));
        assign t_waddr = init_wr ? cnt : wma;
        assign t_wmask = init_wr ? {MB{1'b1}} : col_mask[c];
        assign t_wdata = init_wr ? '0 : wdata_pad[c*MACRO_WIDTH +: MACRO_WIDTH];

        sram_macro_tile #(
          .DW (MACRO_WIDTH),
          .AW (MAW),
          .NM (MB)
        ) u_tile (
          .clk   (clk),
          .wen   (t_wen),
          .waddr (t_waddr),
          .wmask (t_wmask),
          .wdata (t_wdata),
          .ren   (t_ren),
          .raddr (rma),
          .rdata (dout_a[r][c])
        );
      end
    end
  endgenerate

  // ------------------------------------------------------------ read path

  // Expand the byte enables into a bit mask for forwarding.
  always_comb begin
    fwd_bits = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fwd_bits[i] = we[i / BYTE_WIDTH];
    end
  end

  // Stage 1: remember the row to select and any bytes to forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q       <= 1'b0;
      rrow_q     <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      rd_q       <= rd_acc;
      rrow_q     <= rrow;
      fwd_mask_q <= collide ? fwd_bits : '0;
      fwd_data_q <= wdata;
    end
  end

  // Row mux over macro outputs, then write-first merge of forwarded bytes.
  always_comb begin
    row_pad = '0;
    for (int c = 0; c < COLS; c++) begin
      row_pad[c*MACRO_WIDTH +: MACRO_WIDTH] = dout_a[rrow_q][c];
    end
    merged = (row_pad[WIDTH-1:0] & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);
  end

  // Stage 2: output register; rdata holds between valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (rd_q) begin
      rvalid <= 1'b1;
      rdata  <= merged;
    end else begin
      rvalid <= 1'b0;
      rdata  <= rdata;
    end
  end

endmodule
